// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared decoder codes, FSM states, fault and load funct3 codes
package mem_access_unit_pkg;
  localparam logic MEM_READ = 1'b0;
  localparam logic MEM_WRITE = 1'b1;
  localparam logic [1:0] STORE_B = 2'd0;
  localparam logic [1:0] STORE_H = 2'd1;
  localparam logic [1:0] STORE_W = 2'd2;
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  localparam logic [1:0] FAULT_NONE = 2'd0;
  localparam logic [1:0] FAULT_MISALIGN = 2'd1;
  localparam logic [1:0] FAULT_TIMEOUT = 2'd2;
  localparam logic [2:0] LB = 3'b000;
  localparam logic [2:0] LH = 3'b001;
  localparam logic [2:0] LW = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  // 0 byte, 1 halfword, 2 word; unknown load funct3 and store_sel decode as word
  function automatic logic [1:0] access_width(input logic rw, input logic [1:0] store_sel,
                                              input logic [2:0] funct3);
    return rw == MEM_WRITE ? (store_sel == STORE_B ? 2'd0 : store_sel == STORE_H ? 2'd1 : 2'd2)
         : (funct3 == LB || funct3 == LBU) ? 2'd0 : (funct3 == LH || funct3 == LHU) ? 2'd1 : 2'd2;
  endfunction
endpackage

// File: rtl/mem_access_unit_load_extend.sv
// load_extend: select byte/halfword from a read word and sign- or zero-extend it
module load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);
  logic [31:0] shifted;
  logic [7:0] b;
  logic [15:0] h;
  assign shifted = rdata >> {offset, 3'b000};
  assign b = shifted[7:0];
  assign h = offset[1] ? rdata[31:16] : rdata[15:0];
  always_comb
    data = funct3 == LB  ? {{24{b[7]}}, b}
         : funct3 == LH  ? {{16{h[15]}}, h}
         : funct3 == LBU ? {24'd0, b}
         : funct3 == LHU ? {16'd0, h}
         : rdata;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store stage driving a single-outstanding req/ack data bus
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        rw,
  input  logic [1:0]  store_sel,
  input  logic [2:0]  load_funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [1:0]  fault,
  output logic [31:0] load_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);
  state_t state;
  logic [7:0] cnt;
  logic cap_rw, cap_mis;
  logic [2:0] cap_f3;
  logic [1:0] cap_off, width;
  logic mis;
  logic [3:0] be;
  logic [31:0] steered, ext;
  assign width = access_width(rw, store_sel, load_funct3);
  assign mis = width == 2'd1 ? addr[0] : width == 2'd2 ? |addr[1:0] : 1'b0;
  always_comb begin
    be = rw == MEM_READ ? 4'b1111
       : width == 2'd0 ? 4'b0001 << addr[1:0]
       : width == 2'd1 ? (addr[1] ? 4'b1100 : 4'b0011)
       : 4'b1111;
    steered = width == 2'd0 ? {4{wdata[7:0]}} : width == 2'd1 ? {2{wdata[15:0]}} : wdata;
  end
  load_extend u_ext (
    .rdata(bus_rdata),
    .offset(cap_off),
    .funct3(cap_f3),
    .data(ext)
  );
  // A misaligned access still spends one REQ cycle with no request so its
  // completion latency matches the fastest acknowledged access.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      cap_rw <= MEM_READ;
      cap_mis <= 1'b0;
      cap_f3 <= '0;
      cap_off <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      fault <= FAULT_NONE;
      load_data <= '0;
      bus_req <= 1'b0;
      bus_we <= 1'b0;
      bus_be <= '0;
      bus_addr <= '0;
      bus_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          fault <= FAULT_NONE;
          if (start) begin
            state <= REQ;
            busy <= 1'b1;
            cnt <= '0;
            cap_rw <= rw;
            cap_mis <= mis;
            cap_f3 <= load_funct3;
            cap_off <= addr[1:0];
            if (!mis) begin
              bus_req <= 1'b1;
              bus_we <= rw == MEM_WRITE;
              bus_be <= be;
              bus_addr <= {addr[31:2], 2'b00};
              bus_wdata <= steered;
            end
          end
        end
        REQ: begin
          if (cap_mis) begin
            state <= DONE;
            done <= 1'b1;
            fault <= FAULT_MISALIGN;
          end else if (bus_ack) begin
            state <= DONE;
            done <= 1'b1;
            fault <= FAULT_NONE;
            bus_req <= 1'b0;
            if (cap_rw == MEM_READ) load_data <= ext;
          end else if (cnt == 8'(TIMEOUT_CYCLES - 1)) begin
            state <= DONE;
            done <= 1'b1;
            fault <= FAULT_TIMEOUT;
            bus_req <= 1'b0;
          end else cnt <= cnt + 8'd1;
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b0;
          fault <= FAULT_NONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vectors, expected bus requests and completions checked by a scoreboard
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;
  typedef struct {logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wd; logic chk_wd;} bus_t;
  typedef struct {logic [1:0] fault; logic [31:0] ld; int lat; int reqc;} done_t;
  logic clock = 0, reset = 1, start = 0, rw = 0, bus_ack = 0;
  logic [1:0] store_sel = 0;
  logic [2:0] load_funct3 = 0;
  logic [31:0] addr = 0, wdata = 0, bus_rdata = 0;
  logic busy, done, bus_req, bus_we;
  logic [1:0] fault;
  logic [3:0] bus_be;
  logic [31:0] load_data, bus_addr, bus_wdata;
  int cyc = 0, start_cyc = 0, req_cycles = 0, rc = 0, ack_delay = 0, done_seen = 0;
  int passed = 0, total = 0;
  logic ack_en = 1, stray = 0, req_prev = 0;
  logic [68:0] held = '0;
  bus_t bq[$];
  done_t dq[$];

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .start(start), .rw(rw), .store_sel(store_sel),
    .load_funct3(load_funct3), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .fault(fault), .load_data(load_data), .bus_req(bus_req), .bus_we(bus_we),
    .bus_be(bus_be), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // monitor + memory responder
  always @(negedge clock) begin
    bus_t b;
    done_t e;
    if (bus_req) req_cycles++;
    if (bus_req && !req_prev) begin
      if (bq.size() == 0) chk("unexpected_req", 1, 0);
      else begin
        b = bq.pop_front();
        chk("bus_we", bus_we, b.we);
        chk("bus_be", bus_be, b.be);
        chk("bus_addr", bus_addr, b.addr);
        if (b.chk_wd) chk("bus_wdata", bus_wdata, b.wd);
      end
    end else if (bus_req) chk("bus_stable", {bus_we, bus_be, bus_addr, bus_wdata}, held);
    held = {bus_we, bus_be, bus_addr, bus_wdata};
    if (done) begin
      done_seen++;
      if (dq.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = dq.pop_front();
        chk("fault", fault, e.fault);
        chk("load_data", load_data, e.ld);
        chk("latency", cyc - start_cyc, e.lat);
        chk("req_cycles", req_cycles, e.reqc);
      end
    end
    bus_ack = stray || (ack_en && bus_req && rc == ack_delay);
    rc = bus_req ? rc + 1 : 0;
    req_prev = bus_req;
  end

  task automatic issue(input logic r, input logic [1:0] ss, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    @(posedge clock);
    #1;
    start = 1; rw = r; store_sel = ss; load_funct3 = f3; addr = a; wdata = wd;
    start_cyc = cyc;
    req_cycles = 0;
    @(posedge clock);
    #1;
    start = 0;
  endtask

  task automatic op(input logic r, input logic [1:0] ss, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                    input int dly, input logic en, input logic has_req, input logic [3:0] be,
                    input logic [31:0] wd_exp, input logic [1:0] f, input logic [31:0] ld,
                    input int lat, input int reqc);
    int n;
    bus_t b;
    done_t d;
    bus_rdata = rd; ack_delay = dly; ack_en = en;
    b.we = r; b.be = be; b.addr = {a[31:2], 2'b00}; b.wd = wd_exp; b.chk_wd = r;
    if (has_req) bq.push_back(b);
    d.fault = f; d.ld = ld; d.lat = lat; d.reqc = reqc;
    dq.push_back(d);
    n = done_seen;
    issue(r, ss, f3, a, wd);
    for (int i = 0; i < 50 && done_seen == n; i++) begin
      @(negedge clock);
      #1;
    end
    if (done_seen == n) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_state", {busy, done, fault, load_data, bus_req, bus_we, bus_be, bus_addr, bus_wdata}, 0);
    reset = 0;
    op(MEM_WRITE, STORE_W, LW, 32'h100, 32'hDEADBEEF, 0, 0, 1, 1, 4'b1111, 32'hDEADBEEF, FAULT_NONE, 0, 2, 1);
    op(MEM_WRITE, STORE_B, LW, 32'h203, 32'h000000A5, 0, 1, 1, 1, 4'b1000, 32'hA5A5A5A5, FAULT_NONE, 0, 3, 2);
    op(MEM_READ, STORE_W, LB, 32'h2, 0, 32'h80F17F00, 0, 1, 1, 4'b1111, 0, FAULT_NONE, 32'hFFFFFFF1, 2, 1);
    op(MEM_READ, STORE_W, LHU, 32'h2, 0, 32'h80F17F00, 0, 1, 1, 4'b1111, 0, FAULT_NONE, 32'h000080F1, 2, 1);
    op(MEM_READ, STORE_W, LH, 32'h2, 0, 32'h80F17F00, 2, 1, 1, 4'b1111, 0, FAULT_NONE, 32'hFFFF80F1, 4, 3);
    op(MEM_READ, STORE_W, LW, 32'h4, 0, 32'h12345678, 0, 1, 1, 4'b1111, 0, FAULT_NONE, 32'h12345678, 2, 1);
    op(MEM_WRITE, STORE_H, LW, 32'h101, 32'h1234BEEF, 0, 0, 1, 0, 0, 0, FAULT_MISALIGN, 32'h12345678, 2, 0);
    op(MEM_READ, STORE_W, LW, 32'h102, 0, 32'hFFFFFFFF, 0, 1, 0, 0, 0, FAULT_MISALIGN, 32'h12345678, 2, 0);
    op(MEM_READ, STORE_W, 3'b011, 32'h1, 0, 32'hFFFFFFFF, 0, 1, 0, 0, 0, FAULT_MISALIGN, 32'h12345678, 2, 0);
    op(MEM_READ, STORE_W, 3'b011, 32'h8, 0, 32'hCAFEF00D, 0, 1, 1, 4'b1111, 0, FAULT_NONE, 32'hCAFEF00D, 2, 1);
    op(MEM_WRITE, STORE_H, LW, 32'h102, 32'h1234BEEF, 0, 0, 1, 1, 4'b1100, 32'hBEEFBEEF, FAULT_NONE, 32'hCAFEF00D, 2, 1);
    op(MEM_READ, STORE_W, LBU, 32'h3, 0, 32'h80F17F00, 1, 1, 1, 4'b1111, 0, FAULT_NONE, 32'h00000080, 3, 2);
    op(MEM_READ, STORE_W, LB, 32'h1, 0, 32'h80F17F00, 0, 0, 1, 4'b1111, 0, FAULT_TIMEOUT, 32'h00000080, 5, 4);
    op(MEM_READ, STORE_W, LB, 32'h1, 0, 32'h80F17F00, 0, 1, 1, 4'b1111, 0, FAULT_NONE, 32'h0000007F, 2, 1);
    // start during REQ ignored, then reset mid-REQ
    ack_en = 0;
    bq.push_back('{we: 1'b0, be: 4'b1111, addr: 32'h40, wd: 0, chk_wd: 1'b0});
    n = done_seen;
    issue(MEM_READ, STORE_W, LW, 32'h40, 0);
    issue(MEM_WRITE, STORE_W, LW, 32'h80, 32'h11111111);
    chk("second_start_ignored", {bus_req, bus_we, bus_addr}, {1'b1, 1'b0, 32'h40});
    reset = 1;
    @(posedge clock);
    #1;
    reset = 0;
    chk("reset_mid_req", {bus_req, busy}, 0);
    stray = 1;
    repeat (3) @(posedge clock);
    #1;
    stray = 0;
    repeat (3) @(posedge clock);
    #1;
    chk("no_done_after_reset", done_seen, n);
    chk("idle_after_stray_ack", {bus_req, busy}, 0);
    chk("scoreboard_empty", dq.size() + bq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
